uart_tx_multi_pop_serializer: RTL and testbench



---
 rtl/uart_tx_multi_pop_serializer.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_multi_pop_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_multi_pop_serializer.sv
// UART 8N1 transmitter fed by a multi-word pop FIFO: pops up to N words at
// once, buffers them and sends every word LSB byte first, frames back-to-back.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   can_pop   - words available in the FIFO
//   pop       - words taken this cycle (combinational, IDLE only)
//   pop_data  - FIFO head words, word 0 is the oldest
//   tx        - registered serial line, idle high
//   busy      - registered, high while a batch is buffered or being sent
module uart_tx_multi_pop_serializer #(
  parameter int W      = 16,
  parameter int N      = 2,
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  localparam int WN    = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WN-1:0]   can_pop,
  output logic [WN-1:0]   pop,
  input  logic [N*W-1:0]  pop_data,
  output logic            tx,
  output logic            busy
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int BYTES = W / 8;
  localparam int BCW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BYW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WDW   = (N > 1) ? $clog2(N) : 1;

  if ((W % 8) != 0 || W < 8) begin : g_bad_w
    $error("W must be a non-zero multiple of 8");
  end
  if (CPB < 2) begin : g_bad_cpb
    $error("CLK_HZ/BAUD must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state_q, state_n;
  logic           tx_q, tx_n;
  logic           busy_q;
  logic [BCW-1:0] baud_q, baud_n;
  logic [2:0]     bit_q, bit_n;
  logic [BYW-1:0] byte_q, byte_n;
  logic [WDW-1:0] word_q, word_n;
  logic [WN-1:0]  nwords_q, nwords_n;
  logic [7:0]     shift_q, shift_n;
  logic           load;

  logic [W-1:0]   buf_q [N];
  logic [W-1:0]   cur_word;
  logic [7:0]     byte_arr [BYTES];
  logic [7:0]     cur_byte;

  logic           baud_done;
  logic           last_byte;
  logic           last_word;

  assign cur_word = buf_q[word_q];

  always_comb begin
    for (int i = 0; i < BYTES; i++) begin
      byte_arr[i] = cur_word[i*8 +: 8];
    end
  end

  assign cur_byte  = byte_arr[byte_q];
  assign baud_done = (baud_q == BCW'(CPB - 1));
  assign last_byte = (byte_q == BYW'(BYTES - 1));
  assign last_word = ((WN'(word_q) + WN'(1)) == nwords_q);

  // Reset dominates: nothing is taken from the FIFO in a reset cycle.
  always_comb begin
    pop = '0;
    if (state_q == IDLE && !rst) begin
      pop = (can_pop > WN'(N)) ? WN'(N) : can_pop;
    end
  end

  always_comb begin
    state_n  = state_q;
    tx_n     = tx_q;
    baud_n   = baud_q;
    bit_n    = bit_q;
    byte_n   = byte_q;
    word_n   = word_q;
    nwords_n = nwords_q;
    shift_n  = shift_q;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        bit_n  = '0;
        if (pop != '0) begin
          load     = 1'b1;
          nwords_n = pop;
          word_n   = '0;
          byte_n   = '0;
          tx_n     = 1'b0;
          state_n  = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          shift_n = cur_byte;
          tx_n    = cur_byte[0];
          state_n = DATA;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_q == 3'd7) begin
            bit_n   = '0;
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_n   = bit_q + 3'd1;
            shift_n = {1'b0, shift_q[7:1]};
            tx_n    = shift_q[1];
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (!last_byte) begin
            byte_n  = byte_q + 1'b1;
            tx_n    = 1'b0;
            state_n = START;
          end else if (!last_word) begin
            byte_n  = '0;
            word_n  = word_q + 1'b1;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      word_q   <= '0;
      nwords_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_n;
      tx_q     <= tx_n;
      busy_q   <= (state_n != IDLE);
      baud_q   <= baud_n;
      bit_q    <= bit_n;
      byte_q   <= byte_n;
      word_q   <= word_n;
      nwords_q <= nwords_n;
      shift_q  <= shift_n;
    end
  end

  // Words beyond the popped count are latched too; they are never sent.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= pop_data[i*W +: W];
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_multi_pop_serializer.sv
// Directed bench for uart_tx_multi_pop_serializer (W=16, N=2, CPB=4).
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_uart_tx_multi_pop_serializer;

  logic        clk;
  logic        rst;
  logic [1:0]  can_pop;
  logic [1:0]  pop;
  logic [31:0] pop_data;
  logic        tx;
  logic        busy;

  int checks;
  int errors;

  logic [15:0] q[$];
  logic [15:0] wds [2];
  int          n;
  logic [1:0]  exp_pops [3];

  uart_tx_multi_pop_serializer #(
    .W(16),
    .N(2),
    .CLK_HZ(1_000_000),
    .BAUD(250_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .can_pop(can_pop),
    .pop(pop),
    .pop_data(pop_data),
    .tx(tx),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [1:0] exp_pop);
    chk({tag, "_tx"}, {31'b0, tx}, 1);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_pop"}, {30'b0, pop}, {30'b0, exp_pop});
  endtask

  task automatic check_frame(input logic [7:0] b);
    logic bitv;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) bitv = 1'b0;
      else if (i == 9) bitv = 1'b1;
      else bitv = b[i-1];
      for (int c = 0; c < 4; c++) begin
        smp();
        chk($sformatf("tx_%02h_bit%0d_c%0d", b, i, c), {31'b0, tx},
            {31'b0, bitv});
        chk($sformatf("busy_%02h_bit%0d", b, i), {31'b0, busy}, 1);
        chk($sformatf("pop_%02h_bit%0d", b, i), {30'b0, pop}, 0);
        nxt();
      end
    end
  endtask

  task automatic drive_fifo();
    can_pop  = (q.size() >= 2) ? 2'd2 : 2'(q.size());
    pop_data = '0;
    if (q.size() > 0) pop_data[15:0]  = q[0];
    if (q.size() > 1) pop_data[31:16] = q[1];
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    can_pop  = 2'd2;
    pop_data = 32'h0;
    nxt();

    // 1: reset held with can_pop=2
    for (int i = 0; i < 10; i++) begin
      smp();
      chk_idle("rst_hold", 2'd0);
      nxt();
    end

    // 2: single word A55A
    rst      = 1'b0;
    can_pop  = 2'd1;
    pop_data = {16'h0, 16'hA55A};
    smp();
    chk_idle("t2_popcyc", 2'd1);
    nxt();
    can_pop = 2'd0;
    check_frame(8'h5A);
    check_frame(8'hA5);
    smp();
    chk_idle("t2_after", 2'd0);
    nxt();

    // 3: two words, can_pop held at 2
    can_pop  = 2'd2;
    pop_data = {16'h5678, 16'h1234};
    smp();
    chk_idle("t3_popcyc", 2'd2);
    nxt();
    check_frame(8'h34);
    check_frame(8'h12);
    check_frame(8'h78);
    check_frame(8'h56);
    smp();
    chk_idle("t3_repop", 2'd2);
    nxt();
    rst = 1'b1;
    smp();
    chk("t3_rst_pop", {30'b0, pop}, 0);
    nxt();
    rst     = 1'b0;
    can_pop = 2'd0;
    smp();
    chk_idle("t3_post_rst", 2'd0);
    nxt();

    // clamp: can_pop=3 exceeds N
    can_pop  = 2'd3;
    pop_data = {16'h0000, 16'h00AA};
    smp();
    chk_idle("clamp", 2'd2);
    nxt();
    can_pop = 2'd0;
    check_frame(8'hAA);
    check_frame(8'h00);
    check_frame(8'h00);
    check_frame(8'h00);

    // 4: FIFO model holding 1..5
    q = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    exp_pops[0] = 2'd2;
    exp_pops[1] = 2'd2;
    exp_pops[2] = 2'd1;
    for (int b = 0; b < 3; b++) begin
      drive_fifo();
      smp();
      chk_idle($sformatf("fifo_pop%0d", b), exp_pops[b]);
      chk("fifo_pop_le_can", {31'b0, pop <= can_pop}, 1);
      n = int'(pop);
      if (n > 2) n = 2;
      for (int k = 0; k < n; k++) wds[k] = q[k];
      nxt();
      for (int k = 0; k < n; k++) void'(q.pop_front());
      drive_fifo();
      for (int k = 0; k < n; k++) begin
        check_frame(wds[k][7:0]);
        check_frame(wds[k][15:8]);
      end
    end
    drive_fifo();
    smp();
    chk_idle("fifo_empty", 2'd0);
    nxt();

    // 5: reset in mid-batch, then clean batch 00FF
    can_pop  = 2'd1;
    pop_data = {16'h0, 16'hA55A};
    smp();
    chk_idle("t5_popcyc", 2'd1);
    nxt();
    can_pop = 2'd0;
    for (int i = 0; i < 29; i++) begin
      smp();
      chk("t5_busy", {31'b0, busy}, 1);
      nxt();
    end
    rst     = 1'b1;
    can_pop = 2'd1;
    smp();
    chk("t5_rst_pop", {30'b0, pop}, 0);
    nxt();
    rst     = 1'b0;
    can_pop = 2'd0;
    smp();
    chk_idle("t5_post_rst", 2'd0);
    nxt();
    can_pop  = 2'd1;
    pop_data = {16'h0, 16'h00FF};
    smp();
    chk_idle("t5_popcyc2", 2'd1);
    nxt();
    can_pop = 2'd0;
    check_frame(8'hFF);
    check_frame(8'h00);
    smp();
    chk_idle("t5_after", 2'd0);
    nxt();

    // 6: long idle after reset
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      smp();
      chk_idle("idle_long", 2'd0);
      nxt();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
